player_state_engine: RTL and testbench
======================================

# player_state_engine

Game-state side of the per-player control interface: consumes the registered movement/combo commands (crouch, left, right, jump, block, combo level) and owns the authoritative player state. It advances once per game tick, tracks horizontal position and jump height, times attack, crouch and stun animations, and feeds back `isCrouched`, `isInAir`, `isStunned` and `isPerformingAttackAnimation` to the command side. Collision logic drives `hitReceived`; the renderer reads `xPos`, `yPos` and `activeAttack`.

## Interface
- X_INIT, 40: x position after reset
- X_MIN, 0 / X_MAX, 200: saturating x bounds
- WALK_STEP, 2: x change per tick while walking
- JUMP_HEIGHT, 16: apex height in ticks (1 unit/tick)
- CROUCH_TICKS, 6: crouch duration
- STUN_TICKS, 10: stun duration
- ATK1_TICKS, 3 / ATK2_TICKS, 6 / ATK3_TICKS, 10: attack duration per combo level
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- gameTicks  in  1  game tick level; its rising edge is one tick
- isCrouching, movingLeft, movingRight, isJumping, isBlocking  in  1 each  commands
- comboMove  in  2  0 = none, 1 normal, 2 special, 3 super special
- hitReceived  in  1  one-clk hit pulse from collision
- isCrouched, isInAir, isStunned, isPerformingAttackAnimation  out  1 each  state flags
- xPos  out  8  horizontal position
- yPos  out  6  height above ground
- activeAttack  out  2  combo level in progress, 0 when not attacking
- attackStart  out  1  one-clk pulse on attack entry
- blockedHit  out  1  one-clk pulse when a hit is absorbed (HIT_BLOCK_EN only)

## Operation
- States: IDLE, CROUCH, JUMP_UP, JUMP_DOWN, ATTACK, STUN. Flags are decoded from the state: isInAir = JUMP_UP|JUMP_DOWN.
- `tick` = gameTicks & ~gameTicks_q. The state machine, counters and positions change only in cycles where tick=1.
- hitReceived sets `pendingHit` on any clk. pendingHit is consumed and cleared at the next tick.
- Per-tick priority: pendingHit > active countdown > new command.
- pendingHit, any state:
  - go to STUN with counter = STUN_TICKS.
  - yPos forced to 0.
  - A hit during STUN restarts the counter.
- STUN: counter decrements by 1 per tick. When it reaches 0, go to IDLE. No movement.
- ATTACK: counter decrements by 1 per tick. When it reaches 0, go to IDLE and set activeAttack=0. No movement.
- CROUCH: lasts CROUCH_TICKS, then goes to IDLE. No movement.
- IDLE, evaluated in this order:
  - comboMove≠0: go to ATTACK, load the ATKn_TICKS count for that level, activeAttack=comboMove, pulse attackStart.
  - else isJumping: go to JUMP_UP.
  - else isCrouching: go to CROUCH.
  - Walking is applied in the same tick unless ATTACK or CROUCH is entered.
- JUMP_UP: yPos+1 per tick; at JUMP_HEIGHT go to JUMP_DOWN.
- JUMP_DOWN: yPos−1 per tick; at 0 go to IDLE. comboMove is ignored in the air.
- Walking (IDLE, JUMP_UP, JUMP_DOWN):
  - exactly one of movingLeft/movingRight set: x ∓/± WALK_STEP.
  - both or neither set: no move.
  - Arithmetic is 9-bit, then clamped to [X_MIN, X_MAX]. No wrap.
- reset: state IDLE, xPos=X_INIT, yPos=0, all counters, flags, pendingHit, activeAttack, attackStart and blockedHit = 0, gameTicks_q=0. Reset mid-jump or mid-attack takes effect on the next clk.

## Timing
- All outputs are registered. Values from a tick are visible on the clk after the tick cycle.
- Command inputs are sampled only in tick cycles.
- hitReceived coincident with tick is applied at that tick.
- attackStart and blockedHit are high for exactly one clk.
- Jump round trip: 2·JUMP_HEIGHT ticks, i.e. 32 ticks at defaults.
- Attack occupancy is exactly ATKn_TICKS ticks.

## Configuration
- HIT_BLOCK_EN defined: a pendingHit consumed in IDLE or CROUCH while isBlocking=1 is absorbed.
  - No STUN entry; pulse blockedHit instead.
  - Hits in the air, during ATTACK, or during STUN always stun.
- Undefined: isBlocking is ignored, every hit stuns, and blockedHit is tied to 0.

## Structure
- Shared package `player_state_pkg`: state encoding constants, combo level constants (NONE/NORMAL/SPECIAL/SUPER), default duration and bound constants.
- Sub-module `tick_edge`: the gameTicks rising-edge detector (registered sample plus AND). It is reused by other tick-driven blocks.

## Test plan
- Reset, then hold movingRight for 100 ticks -> xPos walks 40, 42, …, saturates at 200 and stays there; movingLeft and movingRight both set -> xPos unchanged.
- isJumping for one tick in IDLE -> isInAir for 32 ticks; yPos peaks at 16, returns to 0, then IDLE.
- comboMove=2 at a tick -> one-clk attackStart, activeAttack=2 and isPerformingAttackAnimation for 6 ticks, then 0; movingLeft during the attack -> xPos unchanged.
- hitReceived mid-jump at yPos=9 -> next tick yPos=0, isStunned for 10 ticks; second hit at stun tick 5 -> stun lasts 10 ticks from that hit.
- With HIT_BLOCK_EN, isBlocking=1 in IDLE plus hitReceived -> blockedHit pulse, isStunned stays 0; rebuilt without the macro -> isStunned for 10 ticks.
- reset asserted at attack tick 2 -> next clk: activeAttack=0, state IDLE, xPos=40.

Source files
------------

// File: rtl/player_state_engine_pkg.sv
// Shared definitions for the player state engine: state encoding, combo levels,
// durations and position bounds.
package player_state_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CROUCH,
    ST_JUMP_UP,
    ST_JUMP_DOWN,
    ST_ATTACK,
    ST_STUN
  } state_t;

  localparam logic [1:0] COMBO_NONE    = 2'd0;
  localparam logic [1:0] COMBO_NORMAL  = 2'd1;
  localparam logic [1:0] COMBO_SPECIAL = 2'd2;
  localparam logic [1:0] COMBO_SUPER   = 2'd3;

  localparam int X_INIT       = 40;
  localparam int X_MIN        = 0;
  localparam int X_MAX        = 200;
  localparam int WALK_STEP    = 2;
  localparam int JUMP_HEIGHT  = 16;
  localparam int CROUCH_TICKS = 6;
  localparam int STUN_TICKS   = 10;
  localparam int ATK1_TICKS   = 3;
  localparam int ATK2_TICKS   = 6;
  localparam int ATK3_TICKS   = 10;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t atk_ticks(input logic [1:0] level);
    case (level)
      COMBO_NORMAL:  atk_ticks = cnt_t'(ATK1_TICKS);
      COMBO_SPECIAL: atk_ticks = cnt_t'(ATK2_TICKS);
      COMBO_SUPER:   atk_ticks = cnt_t'(ATK3_TICKS);
      default:       atk_ticks = '0;
    endcase
  endfunction

endpackage

// File: rtl/player_state_engine_tick_edge.sv
// Rising-edge detector for the game tick level; shared by tick-driven blocks.
module tick_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign tick = level & ~level_q;

endmodule

// File: rtl/player_state_engine.sv
// Authoritative per-player game state, advanced once per game tick.
// Optional HIT_BLOCK_EN: hits taken while blocking on the ground are absorbed.
module player_state_engine
  import player_state_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       gameTicks,
  input  logic       isCrouching,
  input  logic       movingLeft,
  input  logic       movingRight,
  input  logic       isJumping,
  input  logic       isBlocking,
  input  logic [1:0] comboMove,
  input  logic       hitReceived,
  output logic       isCrouched,
  output logic       isInAir,
  output logic       isStunned,
  output logic       isPerformingAttackAnimation,
  output logic [7:0] xPos,
  output logic [5:0] yPos,
  output logic [1:0] activeAttack,
  output logic       attackStart,
  output logic       blockedHit
);

  logic       tick;
  state_t     state, state_nx;
  cnt_t       cnt, cnt_nx;
  logic [7:0] x_q, x_nx, x_walk;
  logic [5:0] y_q, y_nx;
  logic [1:0] atk_q, atk_nx;
  logic       start_q, start_nx;
  logic       blocked_q, blocked_nx;
  logic       pending_hit, pending_nx;
  logic       hit_now;
  logic       absorb;
  logic [8:0] sum9;

  tick_edge u_tick_edge (
    .clk   (clk),
    .reset (reset),
    .level (gameTicks),
    .tick  (tick)
  );

  // A hit arriving in the tick cycle itself counts for that tick.
  assign hit_now = pending_hit | hitReceived;

`ifdef HIT_BLOCK_EN
  assign absorb = isBlocking && (state == ST_IDLE || state == ST_CROUCH);
`else
  logic unused_blocking;
  assign unused_blocking = isBlocking;
  assign absorb          = 1'b0;
`endif

  // Horizontal step with saturation; opposing or absent inputs hold position.
  assign sum9 = {1'b0, x_q} + 9'(WALK_STEP);

  always_comb begin
    x_walk = x_q;
    if (movingRight && !movingLeft) begin
      x_walk = (sum9 > 9'(X_MAX)) ? 8'(X_MAX) : sum9[7:0];
    end else if (movingLeft && !movingRight) begin
      x_walk = (x_q < 8'(X_MIN + WALK_STEP)) ? 8'(X_MIN) : x_q - 8'(WALK_STEP);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      x_q         <= 8'(X_INIT);
      y_q         <= '0;
      atk_q       <= COMBO_NONE;
      start_q     <= 1'b0;
      blocked_q   <= 1'b0;
      pending_hit <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      x_q         <= x_nx;
      y_q         <= y_nx;
      atk_q       <= atk_nx;
      start_q     <= start_nx;
      blocked_q   <= blocked_nx;
      pending_hit <= pending_nx;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nx   = state;
    cnt_nx     = cnt;
    x_nx       = x_q;
    y_nx       = y_q;
    atk_nx     = atk_q;
    start_nx   = 1'b0;
    blocked_nx = 1'b0;
    pending_nx = pending_hit | hitReceived;

    if (tick) begin
      pending_nx = 1'b0;
      if (hit_now && absorb) begin
        blocked_nx = 1'b1;
      end else if (hit_now) begin
        state_nx = ST_STUN;
        cnt_nx   = cnt_t'(STUN_TICKS);
        y_nx     = '0;
        atk_nx   = COMBO_NONE;
      end else begin
        case (state)
          ST_STUN, ST_ATTACK, ST_CROUCH: begin
            if (cnt <= cnt_t'(1)) begin
              state_nx = ST_IDLE;
              cnt_nx   = '0;
              atk_nx   = COMBO_NONE;
            end else begin
              cnt_nx = cnt - cnt_t'(1);
            end
          end
          ST_JUMP_UP: begin
            x_nx = x_walk;
            y_nx = y_q + 6'd1;
            if (y_q + 6'd1 == 6'(JUMP_HEIGHT)) state_nx = ST_JUMP_DOWN;
          end
          ST_JUMP_DOWN: begin
            x_nx = x_walk;
            y_nx = y_q - 6'd1;
            if (y_q == 6'd1) state_nx = ST_IDLE;
          end
          default: begin
            if (comboMove != COMBO_NONE) begin
              state_nx = ST_ATTACK;
              cnt_nx   = atk_ticks(comboMove);
              atk_nx   = comboMove;
              start_nx = 1'b1;
            end else if (isJumping) begin
              state_nx = ST_JUMP_UP;
              x_nx     = x_walk;
            end else if (isCrouching) begin
              state_nx = ST_CROUCH;
              cnt_nx   = cnt_t'(CROUCH_TICKS);
            end else begin
              x_nx = x_walk;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    isCrouched                  = (state == ST_CROUCH);
    isInAir                     = (state == ST_JUMP_UP) || (state == ST_JUMP_DOWN);
    isStunned                   = (state == ST_STUN);
    isPerformingAttackAnimation = (state == ST_ATTACK);
  end

  assign xPos         = x_q;
  assign yPos         = y_q;
  assign activeAttack = atk_q;
  assign attackStart  = start_q;
  assign blockedHit   = blocked_q;

endmodule

// File: tb/tb_player_state_engine.sv
// Scoreboard bench for player_state_engine: stimulus queues expected snapshots,
// a monitor pops and compares them on the clk after each tick or reset.
module tb_player_state_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gameTicks = 1'b0;
  logic       isCrouching = 1'b0, movingLeft = 1'b0, movingRight = 1'b0;
  logic       isJumping = 1'b0, isBlocking = 1'b0;
  logic [1:0] comboMove = 2'd0;
  logic       hitReceived = 1'b0;
  logic       isCrouched, isInAir, isStunned, isPerformingAttackAnimation;
  logic [7:0] xPos;
  logic [5:0] yPos;
  logic [1:0] activeAttack;
  logic       attackStart, blockedHit;

  always #5 clk = ~clk;

  player_state_engine dut (
    .clk                         (clk),
    .reset                       (reset),
    .gameTicks                   (gameTicks),
    .isCrouching                 (isCrouching),
    .movingLeft                  (movingLeft),
    .movingRight                 (movingRight),
    .isJumping                   (isJumping),
    .isBlocking                  (isBlocking),
    .comboMove                   (comboMove),
    .hitReceived                 (hitReceived),
    .isCrouched                  (isCrouched),
    .isInAir                     (isInAir),
    .isStunned                   (isStunned),
    .isPerformingAttackAnimation (isPerformingAttackAnimation),
    .xPos                        (xPos),
    .yPos                        (yPos),
    .activeAttack                (activeAttack),
    .attackStart                 (attackStart),
    .blockedHit                  (blockedHit)
  );

  // Packed as {x, y, crouched, in_air, stunned, attacking, active, start, blocked}.
  typedef logic [21:0] obs_t;
  typedef struct {
    obs_t  o;
    string tag;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cur_x  = 40;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic obs_t mk(input int x, input int y, input bit cr, input bit air,
                              input bit st, input bit an, input int aa, input bit s, input bit b);
    mk = {8'(x), 6'(y), cr, air, st, an, 2'(aa), s, b};
  endfunction

  function automatic obs_t idle_at(input int x);
    idle_at = mk(x, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input obs_t e, input string tag);
    item_t it;
    it.o   = e;
    it.tag = tag;
    exp_q.push_back(it);
  endtask

  // gameTicks stays high for two clks so only a true edge detector advances once.
  task automatic tick(input obs_t e, input string tag, input bit hit = 1'b0);
    @(posedge clk); #2;
    gameTicks   = 1'b1;
    hitReceived = hit;
    push(e, tag);
    @(posedge clk); #2;
    hitReceived = 1'b0;
    @(posedge clk); #2;
    gameTicks = 1'b0;
  endtask

  task automatic pulse_hit();
    @(posedge clk); #2;
    hitReceived = 1'b1;
    @(posedge clk); #2;
    hitReceived = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    reset = 1'b1;
    push(idle_at(40), tag);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  // Monitor: a tick or reset seen at a posedge means the next negedge shows its result.
  logic tick_seen = 1'b0, rst_seen = 1'b0, gt_prev = 1'b0;

  always @(posedge clk) begin
    tick_seen <= gameTicks & ~gt_prev;
    gt_prev   <= gameTicks;
    rst_seen  <= reset;
  end

  always @(negedge clk) begin
    obs_t  got;
    item_t it;
    got = {xPos, yPos, isCrouched, isInAir, isStunned, isPerformingAttackAnimation,
           activeAttack, attackStart, blockedHit};
    if (tick_seen || rst_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, want no output event (t=%0t)", got, $time);
      end else begin
        it = exp_q.pop_front();
        check(it.tag, 32'(got), 32'(it.o));
      end
    end else begin
      check("pulse_width", {30'd0, attackStart, blockedHit}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, want self-finish");
    $fatal(1, "watchdog");
  end

  initial begin
    push(idle_at(40), "reset");
    @(posedge clk); #2;
    reset = 1'b0;

    // Walk right into the upper bound, hold with both, walk left into the lower bound.
    movingRight = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      cur_x = (cur_x + 2 > 200) ? 200 : cur_x + 2;
      tick(idle_at(cur_x), "walk_right");
    end
    movingLeft = 1'b1;
    for (int k = 0; k < 3; k++) tick(idle_at(200), "walk_both");
    movingRight = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      cur_x = (cur_x - 2 < 0) ? 0 : cur_x - 2;
      tick(idle_at(cur_x), "walk_left");
    end
    movingLeft  = 1'b0;
    movingRight = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cur_x += 2;
      tick(idle_at(cur_x), "walk_back");
    end

    // Jump while walking right; a combo in the air is ignored.
    isJumping = 1'b1;
    cur_x += 2;
    tick(mk(cur_x, 0, 0, 1, 0, 0, 0, 0, 0), "jump_start");
    isJumping = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      comboMove = (k == 3) ? 2'd1 : 2'd0;
      cur_x += 2;
      tick(mk(cur_x, (k <= 16) ? k : 32 - k, 0, (k < 32), 0, 0, 0, 0, 0), "jump");
    end
    comboMove   = 2'd0;
    movingRight = 1'b0;

    // Special attack, six ticks, no walking throughout.
    comboMove  = 2'd2;
    movingLeft = 1'b1;
    tick(mk(cur_x, 0, 0, 0, 0, 1, 2, 1, 0), "atk2_start");
    comboMove = 2'd0;
    for (int k = 1; k <= 5; k++) tick(mk(cur_x, 0, 0, 0, 0, 1, 2, 0, 0), "atk2_hold");
    tick(idle_at(cur_x), "atk2_end");
    movingLeft = 1'b0;

    // Combo wins over jump and crouch in the same tick.
    comboMove   = 2'd1;
    isJumping   = 1'b1;
    isCrouching = 1'b1;
    tick(mk(cur_x, 0, 0, 0, 0, 1, 1, 1, 0), "atk1_priority");
    comboMove   = 2'd0;
    isJumping   = 1'b0;
    isCrouching = 1'b0;
    for (int k = 1; k <= 2; k++) tick(mk(cur_x, 0, 0, 0, 0, 1, 1, 0, 0), "atk1_hold");
    tick(idle_at(cur_x), "atk1_end");

    // Crouch, six ticks, walking suppressed.
    isCrouching = 1'b1;
    movingRight = 1'b1;
    tick(mk(cur_x, 0, 1, 0, 0, 0, 0, 0, 0), "crouch_start");
    isCrouching = 1'b0;
    for (int k = 1; k <= 5; k++) tick(mk(cur_x, 0, 1, 0, 0, 0, 0, 0, 0), "crouch_hold");
    tick(idle_at(cur_x), "crouch_end");
    movingRight = 1'b0;

    // Hit at height 9, then a second hit at stun tick 5 restarts the stun.
    isJumping = 1'b1;
    tick(mk(cur_x, 0, 0, 1, 0, 0, 0, 0, 0), "jump2_start");
    isJumping = 1'b0;
    for (int k = 1; k <= 9; k++) tick(mk(cur_x, k, 0, 1, 0, 0, 0, 0, 0), "jump2");
    pulse_hit();
    tick(mk(cur_x, 0, 0, 0, 1, 0, 0, 0, 0), "stun_enter");
    movingRight = 1'b1;
    for (int s = 1; s <= 4; s++) tick(mk(cur_x, 0, 0, 0, 1, 0, 0, 0, 0), "stun_hold");
    pulse_hit();
    for (int s = 5; s <= 14; s++) tick(mk(cur_x, 0, 0, 0, 1, 0, 0, 0, 0), "stun_restart");
    tick(idle_at(cur_x), "stun_end");
    movingRight = 1'b0;

    // Hit while blocking in IDLE.
    isBlocking = 1'b1;
    pulse_hit();
`ifdef HIT_BLOCK_EN
    tick(mk(cur_x, 0, 0, 0, 0, 0, 0, 0, 1), "block_absorb");
    tick(idle_at(cur_x), "block_after");
`else
    tick(mk(cur_x, 0, 0, 0, 1, 0, 0, 0, 0), "block_ignored");
    for (int s = 1; s <= 9; s++) tick(mk(cur_x, 0, 0, 0, 1, 0, 0, 0, 0), "block_stun");
    tick(idle_at(cur_x), "block_stun_end");
`endif
    isBlocking = 1'b0;

    // Hit coincident with the tick edge.
    tick(mk(cur_x, 0, 0, 0, 1, 0, 0, 0, 0), "hit_on_tick", 1'b1);
    for (int s = 1; s <= 9; s++) tick(mk(cur_x, 0, 0, 0, 1, 0, 0, 0, 0), "hit_on_tick_stun");
    tick(idle_at(cur_x), "hit_on_tick_end");

    // Reset at attack tick 2 returns to IDLE at the initial position.
    comboMove = 2'd3;
    tick(mk(cur_x, 0, 0, 0, 0, 1, 3, 1, 0), "atk3_start");
    comboMove = 2'd0;
    for (int k = 1; k <= 2; k++) tick(mk(cur_x, 0, 0, 0, 0, 1, 3, 0, 0), "atk3_hold");
    do_reset("reset_mid_attack");
    cur_x = 40;
    tick(idle_at(cur_x), "after_reset");

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
